// File: rtl/aes_state_loader.sv
// Packs four 32-bit plaintext words from a valid/ready stream into one
// 128-bit block and publishes it atomically to the AES core.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous abort of any partial block
//   in_valid/in_ready      input word handshake (in_data, in_last)
//   state                  published 128-bit block, stable between updates
//   state_valid/ready      block handoff handshake to the consumer
//   err_short              one-cycle pulse when in_last precedes word 4
//   busy                   high while filling or holding a block
module aes_state_loader #(
    parameter int unsigned  WORD_W    = 32,
    parameter logic [127:0] RESET_VAL = 128'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic [127:0]      state,
    output logic              state_valid,
    input  logic              state_ready,
    output logic              err_short,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t              fsm, fsm_d;
    logic [1:0]        wcnt, wcnt_d;
    // Only words 0..2 need buffering; word 3 goes straight into `state`.
    logic [3*WORD_W-1:0] blk_buf, blk_buf_d;
    logic [127:0]      state_d;
    logic              sv_d;
    logic              err_d;
    logic              accept;

    assign in_ready = (fsm != HOLD);
    assign busy     = (fsm != IDLE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= IDLE;
            wcnt        <= 2'd0;
            blk_buf     <= '0;
            state       <= RESET_VAL;
            state_valid <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            fsm         <= fsm_d;
            wcnt        <= wcnt_d;
            blk_buf     <= blk_buf_d;
            state       <= state_d;
            state_valid <= sv_d;
            err_short   <= err_d;
        end
    end

    always_comb begin
        fsm_d     = fsm;
        wcnt_d    = wcnt;
        blk_buf_d = blk_buf;
        state_d   = state;
        sv_d      = state_valid;
        err_d     = 1'b0;

        if (flush) begin
            // Flush drops any same-cycle accept or handoff; `state` is kept.
            fsm_d  = IDLE;
            wcnt_d = 2'd0;
            sv_d   = 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            err_d = 1'b1;
                        end else begin
                            blk_buf_d[3*WORD_W-1 -: WORD_W] = in_data;
                            wcnt_d = 2'd1;
                            fsm_d  = FILL;
                        end
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (wcnt == 2'd3) begin
                            // in_last is ignored on the fourth word.
                            state_d = {blk_buf, in_data};
                            sv_d    = 1'b1;
                            wcnt_d  = 2'd0;
                            fsm_d   = HOLD;
                        end else if (in_last) begin
                            err_d  = 1'b1;
                            wcnt_d = 2'd0;
                            fsm_d  = IDLE;
                        end else begin
                            case (wcnt)
                                2'd1:    blk_buf_d[2*WORD_W-1 -: WORD_W] = in_data;
                                2'd2:    blk_buf_d[WORD_W-1 -: WORD_W] = in_data;
                                default: blk_buf_d[3*WORD_W-1 -: WORD_W] = in_data;
                            endcase
                            wcnt_d = wcnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (state_valid && state_ready) begin
                        sv_d  = 1'b0;
                        fsm_d = IDLE;
                    end
                end
                default: begin
                    fsm_d  = IDLE;
                    wcnt_d = 2'd0;
                    sv_d   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_state_loader.sv
// Directed testbench for aes_state_loader with a queue-based scoreboard
// checking every block handed off on state_valid/state_ready.
module tb_aes_state_loader;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [127:0] state;
    logic         state_valid;
    logic         state_ready = 1'b0;
    logic         err_short;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_seen = 0;
    logic prev_err = 1'b0;
    logic [127:0] exp_q[$];
    int hs_cyc[$];

    aes_state_loader #(.WORD_W(32), .RESET_VAL(128'h0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .state(state), .state_valid(state_valid),
        .state_ready(state_ready), .err_short(err_short), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each handed-off block with the queue.
    always @(negedge clk) begin
        if (rst_n && state_valid && state_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL handoff: got %h expected none", state);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (state !== e) begin
                    fails++;
                    $display("FAIL handoff: got %h expected %h", state, e);
                end
            end
            hs_cyc.push_back(cyc);
        end
        if (err_short === 1'b1) begin
            err_seen++;
            if (prev_err) begin
                tests++;
                fails++;
                $display("FAIL err_width: got 2+ cycles expected 1");
            end
        end
        prev_err = (err_short === 1'b1);
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] b);
        send_word(b[127:96], 1'b0);
        send_word(b[95:64], 1'b0);
        send_word(b[63:32], 1'b0);
        send_word(b[31:0], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] b1, b2, b3;
        logic [127:0] bb[3];
        int n, base;
        b1 = 128'h00112233_44556677_8899aabb_ccddeeff;
        b2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        b3 = 128'h11111111_22222222_33333333_44444444;
        bb[0] = 128'ha0a0a0a0_a1a1a1a1_a2a2a2a2_a3a3a3a3;
        bb[1] = 128'hb0b0b0b0_b1b1b1b1_b2b2b2b2_b3b3b3b3;
        bb[2] = 128'hc0c0c0c0_c1c1c1c1_c2c2c2c2_c3c3c3c3;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 128'h0);
        check("rst_valid", {127'h0, state_valid}, 128'h0);
        check("rst_ready", {127'h0, in_ready}, 128'h1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {127'h0, busy}, 128'h0);

        // 1: basic block, no intermediate state change
        exp_q.push_back(b1);
        send_word(b1[127:96], 1'b0);
        check("t1_busy", {127'h0, busy}, 128'h1);
        send_word(b1[95:64], 1'b0);
        send_word(b1[63:32], 1'b0);
        check("t1_mid_state", state, 128'h0);
        check("t1_mid_valid", {127'h0, state_valid}, 128'h0);
        send_word(b1[31:0], 1'b1);
        check("t1_state", state, b1);
        check("t1_valid", {127'h0, state_valid}, 128'h1);

        // 2: hold without consumer
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t2_ready_low", {127'h0, in_ready}, 128'h0);
            check("t2_stable", state, b1);
        end
        state_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_valid_drop", {127'h0, state_valid}, 128'h0);
        check("t2_ready_up", {127'h0, in_ready}, 128'h1);
        check("t2_state_kept", state, b1);

        // 3: short block
        send_word(32'h0badf00d, 1'b0);
        send_word(32'h12345678, 1'b1);
        check("t3_err", {127'h0, err_short}, 128'h1);
        check("t3_idle", {127'h0, busy}, 128'h0);
        check("t3_state", state, b1);
        @(posedge clk);
        #1;
        check("t3_err_end", {127'h0, err_short}, 128'h0);
        exp_q.push_back(b2);
        send_block(b2);
        check("t3_block", state, b2);

        // 4: flush after word 3, with a dropped same-cycle word
        send_word(32'h99999999, 1'b0);
        send_word(32'h88888888, 1'b0);
        send_word(32'h77777777, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h66666666;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_idle", {127'h0, busy}, 128'h0);
        check("t4_state_kept", state, b2);
        check("t4_err", {127'h0, err_short}, 128'h0);
        exp_q.push_back(b3);
        send_block(b3);
        check("t4_block", state, b3);

        // 5: async reset mid-fill
        send_word(32'h55555555, 1'b0);
        send_word(32'h44444444, 1'b0);
        check("t5_pre_state", state, b3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_state", state, 128'h0);
        check("t5_valid", {127'h0, state_valid}, 128'h0);
        check("t5_busy", {127'h0, busy}, 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 6: back-to-back blocks with stream and consumer always ready
        base = hs_cyc.size();
        for (int k = 0; k < 3; k++) exp_q.push_back(bb[k]);
        begin
            int idx;
            logic r;
            idx = 0;
            n = 0;
            in_valid = 1'b1;
            while (idx < 12 && n < 100) begin
                in_data = bb[idx / 4][127 - 32 * (idx % 4) -: 32];
                in_last = (idx % 4 == 3);
                r = in_ready;
                @(posedge clk);
                #1;
                if (r) idx++;
                n++;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_drained", exp_q.size(), 0);
        check("t6_count", hs_cyc.size() - base, 3);
        if (hs_cyc.size() - base == 3) begin
            check("t6_gap1", hs_cyc[base + 1] - hs_cyc[base], 5);
            check("t6_gap2", hs_cyc[base + 2] - hs_cyc[base + 1], 5);
        end
        check("err_total", err_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
